// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
package booth_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Booth decode of {Q[0], q_m1}; 2'b11 behaves like BOOTH_NOP
   localparam logic [1:0] BOOTH_NOP = 2'b00;
   localparam logic [1:0] BOOTH_ADD = 2'b01;
   localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_seq_mult_step.sv
// One radix-2 Booth step: conditional add/subtract of M into A, then an
// arithmetic right shift of {A, Q, q_m1} that replicates the sign of A.
module booth_step
   import booth_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH:0]   a,
   input  logic [WIDTH-1:0] q,
   input  logic             q_m1,
   input  logic [WIDTH:0]   m,
   output logic [WIDTH:0]   a_next,
   output logic [WIDTH-1:0] q_next,
   output logic             q_m1_next
);

   logic [WIDTH:0] sum;

   // add/subtract selected by the current Booth pair, then shift
   always_comb begin
      sum = a;
      case ({q[0], q_m1})
         BOOTH_ADD: sum = a + m;
         BOOTH_SUB: sum = a - m;
         default:   sum = a;
      endcase
      a_next    = {sum[WIDTH], sum[WIDTH:1]};
      q_next    = {sum[0], q[WIDTH-1:1]};
      q_m1_next = q[0];
   end

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier: accepts a signed operand pair,
// runs WIDTH Booth steps and holds the 2*WIDTH-bit product until consumed.
//
//   state | meaning
//   IDLE  | in_ready high, waiting for an operand pair
//   RUN   | one Booth step per cycle, count runs WIDTH..1
//   DONE  | out_valid high, product held until out_ready
module booth_seq_mult
   import booth_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t           state;
   logic [WIDTH:0]   a;
   logic [WIDTH:0]   m;
   logic [WIDTH-1:0] q;
   logic             q_m1;
   logic [CW-1:0]    count;

   logic [WIDTH:0]   a_next;
   logic [WIDTH-1:0] q_next;
   logic             q_m1_next;

   booth_step #(.WIDTH(WIDTH)) u_step (
      .a         (a),
      .q         (q),
      .q_m1      (q_m1),
      .m         (m),
      .a_next    (a_next),
      .q_next    (q_next),
      .q_m1_next (q_m1_next)
   );

   // handshake outputs decode straight from state so reset clears them at once
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

   // control FSM, datapath registers and product capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         a       <= '0;
         m       <= '0;
         q       <= '0;
         q_m1    <= 1'b0;
         count   <= '0;
         product <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a     <= '0;
                  q     <= multiplier;
                  q_m1  <= 1'b0;
                  // one extra bit so -M of the most negative value fits
                  m     <= {multiplicand[WIDTH-1], multiplicand};
                  count <= CW'(WIDTH);
                  state <= RUN;
               end
            end
            RUN: begin
               a     <= a_next;
               q     <= q_next;
               q_m1  <= q_m1_next;
               count <= count - CW'(1);
               if (count == CW'(1)) begin
                  product <= {a_next[WIDTH-1:0], q_next};
                  state   <= DONE;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_seq_mult.sv
// Self-checking bench for booth_seq_mult (WIDTH=8) against a plain
// signed-multiply reference model.
module tb_booth_seq_mult;

   localparam int W = 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [W-1:0]    multiplicand;
   logic [W-1:0]    multiplier;
   logic            out_valid;
   logic            out_ready;
   logic [2*W-1:0]  product;
   logic            busy;

   int n_checks = 0;
   int n_pass   = 0;

   booth_seq_mult #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .product      (product),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
      logic signed [2*W-1:0] sx;
      logic signed [2*W-1:0] sy;
      sx = $signed(x);
      sy = $signed(y);
      return sx * sy;
   endfunction

   // drive one operation; returns product seen when out_valid rose, the
   // number of edges from accept to out_valid, and in_ready one edge later
   task automatic do_op(input logic [W-1:0] mm, input logic [W-1:0] qq, input logic rdy,
                        output logic [2*W-1:0] p, output int lat, output logic ir_after);
      @(negedge clk);
      multiplicand = mm;
      multiplier   = qq;
      in_valid     = 1'b1;
      out_ready    = rdy;
      @(posedge clk);
      #1;
      in_valid     = 1'b0;
      multiplicand = W'($urandom);
      multiplier   = W'($urandom);
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk);
         lat++;
         #1;
      end
      p = product;
      ir_after = 1'b0;
      if (rdy) begin
         @(posedge clk);
         #1;
         ir_after = in_ready;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      multiplicand = '0; multiplier = '0;
      #3;
      n_checks++;
      if ({in_ready, out_valid, busy, product} !== {1'b1, 1'b0, 1'b0, 16'h0})
         $display("FAIL reset: got in_ready=%b out_valid=%b busy=%b product=%h, want 1 0 0 0000",
                  in_ready, out_valid, busy, product);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      logic [2*W-1:0] p; int lat; logic ir;
      do_op(8'd3, 8'd5, 1'b1, p, lat, ir);
      n_checks++;
      if (p !== 16'h000F) $display("FAIL basic_product: got %h want 000f", p); else n_pass++;
      n_checks++;
      if (lat !== W) $display("FAIL basic_latency: got %0d want %0d", lat, W); else n_pass++;
      n_checks++;
      if (ir !== 1'b1) $display("FAIL basic_in_ready_after: got %b want 1", ir); else n_pass++;
   endtask

   task automatic test_mixed();
      logic [2*W-1:0] p; int lat; logic ir;
      do_op(8'hF9, 8'd6, 1'b1, p, lat, ir);
      n_checks++;
      if (p !== 16'hFFD6) $display("FAIL mixed_m7x6: got %h want ffd6", p); else n_pass++;
      do_op(8'd6, 8'hF9, 1'b1, p, lat, ir);
      n_checks++;
      if (p !== 16'hFFD6) $display("FAIL mixed_6xm7: got %h want ffd6", p); else n_pass++;
   endtask

   task automatic test_extremes();
      logic [2*W-1:0] p; int lat; logic ir;
      do_op(8'h80, 8'h80, 1'b1, p, lat, ir);
      n_checks++;
      if (p !== 16'h4000) $display("FAIL ext_min_min: got %h want 4000", p); else n_pass++;
      do_op(8'h7F, 8'h80, 1'b1, p, lat, ir);
      n_checks++;
      if (p !== 16'hC080) $display("FAIL ext_max_min: got %h want c080", p); else n_pass++;
      do_op(8'h00, 8'hFF, 1'b1, p, lat, ir);
      n_checks++;
      if (p !== 16'h0000) $display("FAIL ext_zero: got %h want 0000", p); else n_pass++;
   endtask

   task automatic test_backpressure();
      logic [2*W-1:0] p; logic [2*W-1:0] exp_p; int lat; logic ir; int bad;
      exp_p = ref_mul(8'hD3, 8'h1B);
      do_op(8'hD3, 8'h1B, 1'b0, p, lat, ir);
      n_checks++;
      if (p !== exp_p || lat !== W) $display("FAIL bp_product: got %h lat %0d want %h lat %0d", p, lat, exp_p, W);
      else n_pass++;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid     = 1'b1;
         multiplicand = W'($urandom);
         multiplier   = W'($urandom);
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || product !== exp_p) bad++;
      end
      n_checks++;
      if (bad != 0) $display("FAIL bp_hold: got %0d unstable cycles, want 0", bad); else n_pass++;
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if ({out_valid, in_ready, busy, product} !== {1'b0, 1'b1, 1'b0, exp_p})
         $display("FAIL bp_consume: got out_valid=%b in_ready=%b busy=%b product=%h, want 0 1 0 %h",
                  out_valid, in_ready, busy, product, exp_p);
      else n_pass++;
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      logic [2*W-1:0] p; int lat; logic ir;
      @(negedge clk);
      multiplicand = 8'h55; multiplier = 8'hA3; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({out_valid, busy, in_ready, product} !== {1'b0, 1'b0, 1'b1, 16'h0})
         $display("FAIL rst_mid_run: got out_valid=%b busy=%b in_ready=%b product=%h, want 0 0 1 0000",
                  out_valid, busy, in_ready, product);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      do_op(8'd2, 8'hFD, 1'b1, p, lat, ir);
      n_checks++;
      if (p !== 16'hFFFA || lat !== W) $display("FAIL rst_then_op: got %h lat %0d want fffa lat %0d", p, lat, W);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [W-1:0]   ms [20];
      logic [W-1:0]   qs [20];
      logic [2*W-1:0] exp_q [$];
      int sent, got, cyc, errs;
      logic [2*W-1:0] e;
      for (int i = 0; i < 20; i++) begin
         ms[i] = W'($urandom);
         qs[i] = W'($urandom);
      end
      sent = 0; got = 0; cyc = 0; errs = 0;
      while (got < 20 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         out_ready = 1'($urandom);
         if (sent < 20) begin
            in_valid = 1'b1;
            multiplicand = ms[sent];
            multiplier   = qs[sent];
         end else begin
            in_valid = 1'b0;
         end
         if (out_valid && out_ready) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            n_checks++;
            if (product !== e) begin
               $display("FAIL b2b_product[%0d]: got %h want %h", got, product, e);
               errs++;
            end else n_pass++;
            got++;
         end
         if (in_ready && in_valid) begin
            exp_q.push_back(ref_mul(ms[sent], qs[sent]));
            sent++;
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      n_checks++;
      if (got != 20 || sent != 20 || exp_q.size() != 0)
         $display("FAIL b2b_count: got %0d results %0d sent %0d pending, want 20 20 0", got, sent, exp_q.size());
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_mixed();
      test_extremes();
      test_backpressure();
      test_reset_mid_run();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
